// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS fetch stage.
// The PCSrc encodings match what the ID-stage control decoder drives.
package mips_pkg;

  localparam logic [2:0] PCSRC_SEQ = 3'b000;
  localparam logic [2:0] PCSRC_BR  = 3'b001;
  localparam logic [2:0] PCSRC_J   = 3'b010;
  localparam logic [2:0] PCSRC_JR  = 3'b011;
  localparam logic [2:0] PCSRC_IRQ = 3'b100;
  localparam logic [2:0] PCSRC_EXC = 3'b101;

  localparam logic [31:0] RESET_PC  = 32'h8000_0000;
  localparam logic [31:0] ILLOP_PC  = 32'h8000_0004;
  localparam logic [31:0] XADR_PC   = 32'h8000_0008;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  typedef enum logic [2:0] {
    SEL_BRANCH,
    SEL_HOLD,
    SEL_IRQ,
    SEL_EXC,
    SEL_JUMP,
    SEL_JR,
    SEL_SEQ
  } pc_sel_e;

  // The supervisor bit PC[31] is never carried into by a sequential increment.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return {pc[31], pc[30:0] + 31'd4};
  endfunction

endpackage

// File: rtl/if_pc_next.sv
// Combinational next-PC and IF/ID next-value selection for the fetch stage.
// An EX branch outranks a stall; ID redirects are honoured only for a valid ID instruction.
module if_pc_next
  import mips_pkg::*;
(
  input  logic [31:0] pc_i,
  input  if_id_t      if_id_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [2:0]  pcsrc_i,
  input  logic [25:0] jump_target_i,
  input  logic [31:0] jr_target_i,
  input  logic        ex_branch_i,
  input  logic [31:0] ex_branch_target_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_next_o,
  output if_id_t      if_id_next_o,
  output logic        irq_taken_o
);

  pc_sel_e     sel;
  logic [31:0] seq_pc;
  if_id_t      bubble;

  always_comb begin
    sel = SEL_SEQ;
    if (ex_branch_i) begin
      sel = SEL_BRANCH;
    end else if (stall_i) begin
      sel = SEL_HOLD;
    end else if (if_id_i.valid) begin
      case (pcsrc_i)
        PCSRC_IRQ: sel = SEL_IRQ;
        PCSRC_EXC: sel = SEL_EXC;
        PCSRC_J:   sel = SEL_JUMP;
        PCSRC_JR:  sel = SEL_JR;
        default:   sel = SEL_SEQ;
      endcase
    end
  end

  // A bubble keeps the old pc4 so that only instr and valid change.
  always_comb begin
    seq_pc       = pc_plus4(pc_i);
    bubble       = '{instr: NOP_INSTR, pc4: if_id_i.pc4, valid: 1'b0};
    pc_next_o    = seq_pc;
    if_id_next_o = '{instr: imem_rdata_i, pc4: seq_pc, valid: 1'b1};
    case (sel)
      SEL_BRANCH: begin
        pc_next_o    = ex_branch_target_i;
        if_id_next_o = bubble;
      end
      SEL_HOLD: begin
        pc_next_o    = pc_i;
        if_id_next_o = if_id_i;
      end
      SEL_IRQ: begin
        pc_next_o    = ILLOP_PC;
        if_id_next_o = bubble;
      end
      SEL_EXC: begin
        pc_next_o    = XADR_PC;
        if_id_next_o = bubble;
      end
      SEL_JUMP: begin
        pc_next_o    = {if_id_i.pc4[31:28], jump_target_i, 2'b00};
        if_id_next_o = bubble;
      end
      SEL_JR: begin
        pc_next_o    = jr_target_i;
        if_id_next_o = bubble;
      end
      default: begin
        pc_next_o    = seq_pc;
        if_id_next_o = '{instr: imem_rdata_i, pc4: seq_pc, valid: 1'b1};
      end
    endcase
    if (flush_i) begin
      if_id_next_o = bubble;
    end
  end

  assign irq_taken_o = (sel == SEL_IRQ);

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and sticky IRQ-pending flag.
// Next-state selection lives in if_pc_next; this module only holds the flops.
module if_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [2:0]  pcsrc_i,
  input  logic [25:0] jump_target_i,
  input  logic [31:0] jr_target_i,
  input  logic        ex_branch_i,
  input  logic [31:0] ex_branch_target_i,
  input  logic        irq_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] if_id_instr_o,
  output logic [31:0] if_id_pc4_o,
  output logic        if_id_valid_o,
  output logic        irq_o
);

  logic [31:0] pc_q, pc_d;
  if_id_t      if_id_q, if_id_d;
  logic        irq_pending_q, irq_pending_d;
  logic        irq_taken;

  if_pc_next u_pc_next (
    .pc_i               (pc_q),
    .if_id_i            (if_id_q),
    .stall_i            (stall_i),
    .flush_i            (flush_i),
    .pcsrc_i            (pcsrc_i),
    .jump_target_i      (jump_target_i),
    .jr_target_i        (jr_target_i),
    .ex_branch_i        (ex_branch_i),
    .ex_branch_target_i (ex_branch_target_i),
    .imem_rdata_i       (imem_rdata_i),
    .pc_next_o          (pc_d),
    .if_id_next_o       (if_id_d),
    .irq_taken_o        (irq_taken)
  );

  // Only user-mode interrupts latch; a set racing the vector clear survives only if we stay in user mode.
  always_comb begin
    irq_pending_d = irq_pending_q;
    if (irq_taken) begin
      irq_pending_d = 1'b0;
    end
    if (irq_i && !pc_q[31] && !(irq_taken && pc_d[31])) begin
      irq_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      if_id_q       <= '{instr: NOP_INSTR, pc4: 32'h0, valid: 1'b0};
      irq_pending_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      if_id_q       <= if_id_d;
      irq_pending_q <= irq_pending_d;
    end
  end

  assign imem_addr_o   = pc_q;
  assign if_id_instr_o = if_id_q.instr;
  assign if_id_pc4_o   = if_id_q.pc4;
  assign if_id_valid_o = if_id_q.valid;
  assign irq_o         = irq_pending_q & if_id_q.valid & ~if_id_q.pc4[31];

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a cycle-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [2:0]  pcsrc;
  logic [25:0] jumpTarget;
  logic [31:0] jrTarget;
  logic        exBranch;
  logic [31:0] exTarget;
  logic        irq;
  logic [31:0] imemAddr;
  logic [31:0] imemRdata;
  logic [31:0] ifIdInstr;
  logic [31:0] ifIdPc4;
  logic        ifIdValid;
  logic        irqOut;

  int assertCount = 0;
  int failCount   = 0;
  bit checkOn     = 1'b0;

  logic [31:0] mPc, mInstr, mPc4;
  logic        mValid, mPend;

  if_stage dut (
    .clk                (clk),
    .reset              (reset),
    .stall_i            (stall),
    .flush_i            (flush),
    .pcsrc_i            (pcsrc),
    .jump_target_i      (jumpTarget),
    .jr_target_i        (jrTarget),
    .ex_branch_i        (exBranch),
    .ex_branch_target_i (exTarget),
    .irq_i              (irq),
    .imem_addr_o        (imemAddr),
    .imem_rdata_i       (imemRdata),
    .if_id_instr_o      (ifIdInstr),
    .if_id_pc4_o        (ifIdPc4),
    .if_id_valid_o      (ifIdValid),
    .irq_o              (irqOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: each word is a simple function of its address.
  function automatic logic [31:0] imemWord(input logic [31:0] a);
    return a ^ 32'hC3C3_A5A5;
  endfunction

  assign imemRdata = imemWord(imemAddr);

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Reference model of the fetch stage, stepped on each rising edge from the priority rules.
  always @(posedge clk) begin : refModel
    logic [31:0] seqPc, nPc, nInstr, nPc4;
    logic        nValid, taken, nPend, redirect;
    if (reset) begin
      mPc    <= 32'h8000_0000;
      mInstr <= 32'h0;
      mPc4   <= 32'h0;
      mValid <= 1'b0;
      mPend  <= 1'b0;
    end else begin
      seqPc    = {mPc[31], mPc[30:0] + 31'd4};
      nPc      = seqPc;
      nInstr   = imemWord(mPc);
      nPc4     = seqPc;
      nValid   = 1'b1;
      taken    = 1'b0;
      redirect = 1'b0;
      if (exBranch) begin
        nPc      = exTarget;
        redirect = 1'b1;
      end else if (stall) begin
        nPc    = mPc;
        nInstr = mInstr;
        nPc4   = mPc4;
        nValid = mValid;
      end else if (mValid) begin
        case (pcsrc)
          3'b100: begin nPc = 32'h8000_0004; redirect = 1'b1; taken = 1'b1; end
          3'b101: begin nPc = 32'h8000_0008; redirect = 1'b1; end
          3'b010: begin nPc = {mPc4[31:28], jumpTarget, 2'b00}; redirect = 1'b1; end
          3'b011: begin nPc = jrTarget; redirect = 1'b1; end
          default: ;
        endcase
      end
      if (redirect || flush) begin
        nInstr = 32'h0;
        nPc4   = mPc4;
        nValid = 1'b0;
      end
      nPend = taken ? 1'b0 : mPend;
      if (irq && !mPc[31]) nPend = taken ? !nPc[31] : 1'b1;
      mPc    <= nPc;
      mInstr <= nInstr;
      mPc4   <= nPc4;
      mValid <= nValid;
      mPend  <= nPend;
    end
  end

  // Every-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    if (checkOn) begin
      checkOutput("model pc", imemAddr, mPc);
      checkOutput("model valid", {31'b0, ifIdValid}, {31'b0, mValid});
      checkOutput("model instr", ifIdInstr, mInstr);
      if (mValid) checkOutput("model pc4", ifIdPc4, mPc4);
      checkOutput("model irq_o", {31'b0, irqOut}, {31'b0, mPend & mValid & ~mPc4[31]});
    end
  end

  // One cycle of stimulus; tgt feeds jr, EX branch and (bits 27:2) the jump field.
  task automatic applyStimulus(input logic [2:0] src, input logic stl, input logic fl,
                               input logic br, input logic [31:0] tgt, input logic irqIn);
    pcsrc      = src;
    stall      = stl;
    flush      = fl;
    exBranch   = br;
    exTarget   = tgt;
    jrTarget   = tgt;
    jumpTarget = tgt[27:2];
    irq        = irqIn;
    @(negedge clk);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, " pc"}, imemAddr, 32'h8000_0000);
    checkOutput({tag, " instr"}, ifIdInstr, 32'h0);
    checkOutput({tag, " pc4"}, ifIdPc4, 32'h0);
    checkOutput({tag, " valid"}, {31'b0, ifIdValid}, 32'h0);
    checkOutput({tag, " irq_o"}, {31'b0, irqOut}, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0; flush = 1'b0; pcsrc = 3'b000; jumpTarget = '0;
    jrTarget = '0; exBranch = 1'b0; exTarget = '0; irq = 1'b0;
    @(posedge clk);
    checkOn = 1'b1;
    repeat (2) @(negedge clk);
    checkReset("reset");
    reset = 1'b0;

    // Sequential fetch out of reset
    applyStimulus(3'b000, 0, 0, 0, 32'h0, 0);
    checkOutput("seq1 pc", imemAddr, 32'h8000_0004);
    checkOutput("seq1 pc4", ifIdPc4, 32'h8000_0004);
    checkOutput("seq1 instr", ifIdInstr, 32'h8000_0000 ^ 32'hC3C3_A5A5);
    applyStimulus(3'b000, 0, 0, 0, 32'h0, 0);
    checkOutput("seq2 pc", imemAddr, 32'h8000_0008);

    // Kernel jr to 80000100, then jr from there into user space
    applyStimulus(3'b011, 0, 0, 0, 32'h8000_0100, 0);
    applyStimulus(3'b000, 0, 0, 0, 32'h0, 0);
    checkOutput("kern pc4", ifIdPc4, 32'h8000_0104);
    applyStimulus(3'b011, 0, 0, 0, 32'h0040_0000, 0);
    checkOutput("jr user pc", imemAddr, 32'h0040_0000);
    checkOutput("jr bubble", {31'b0, ifIdValid}, 32'h0);
    repeat (4) applyStimulus(3'b000, 0, 0, 0, 32'h0, 0);
    checkOutput("user pc4", ifIdPc4, 32'h0040_0010);

    // Jump with one bubble
    applyStimulus(3'b010, 0, 0, 0, 32'h0040_0100, 0);
    checkOutput("jump pc", imemAddr, 32'h0040_0100);
    checkOutput("jump bubble", {31'b0, ifIdValid}, 32'h0);
    applyStimulus(3'b000, 0, 0, 0, 32'h0, 0);
    checkOutput("jump one bubble", {31'b0, ifIdValid}, 32'h1);

    // Stall freezes pc and IF/ID while a jump waits in ID
    repeat (2) applyStimulus(3'b010, 1, 0, 0, 32'h0040_0200, 0);
    checkOutput("stall pc", imemAddr, 32'h0040_0104);
    checkOutput("stall pc4", ifIdPc4, 32'h0040_0104);
    applyStimulus(3'b010, 0, 0, 0, 32'h0040_0200, 0);
    checkOutput("post-stall jump", imemAddr, 32'h0040_0200);
    applyStimulus(3'b000, 0, 0, 0, 32'h0, 0);

    // EX branch beats a simultaneous stall
    applyStimulus(3'b000, 1, 0, 1, 32'h0040_0200, 0);
    checkOutput("branch pc", imemAddr, 32'h0040_0200);
    checkOutput("branch bubble", {31'b0, ifIdValid}, 32'h0);
    applyStimulus(3'b000, 0, 0, 0, 32'h0, 0);

    // Flush keeps pc4, then a redirect during a bubble is ignored
    applyStimulus(3'b000, 0, 1, 0, 32'h0, 0);
    checkOutput("flush pc", imemAddr, 32'h0040_0208);
    checkOutput("flush pc4 kept", ifIdPc4, 32'h0040_0204);
    checkOutput("flush instr", ifIdInstr, 32'h0);
    applyStimulus(3'b011, 0, 0, 0, 32'h1234_5678, 0);
    checkOutput("bubble ignores pcsrc", imemAddr, 32'h0040_020C);

    // User-mode interrupt and its vector
    applyStimulus(3'b010, 0, 0, 0, 32'h0040_0020, 0);
    checkOutput("jump 20 pc", imemAddr, 32'h0040_0020);
    applyStimulus(3'b000, 0, 0, 0, 32'h0, 1);
    checkOutput("irq raised", {31'b0, irqOut}, 32'h1);
    applyStimulus(3'b100, 0, 0, 0, 32'h0, 0);
    checkOutput("irq vector pc", imemAddr, 32'h8000_0004);
    checkOutput("irq vector irq_o", {31'b0, irqOut}, 32'h0);
    applyStimulus(3'b000, 0, 0, 0, 32'h0, 0);
    repeat (2) applyStimulus(3'b000, 0, 0, 0, 32'h0, 1);
    checkOutput("kernel irq_o", {31'b0, irqOut}, 32'h0);

    // Exception vector
    applyStimulus(3'b101, 0, 0, 0, 32'h0, 0);
    checkOutput("exc pc", imemAddr, 32'h8000_0008);
    applyStimulus(3'b000, 0, 0, 0, 32'h0, 0);

    // Increment wrap keeps bit 31 in both modes
    applyStimulus(3'b011, 0, 0, 0, 32'hFFFF_FFFC, 0);
    applyStimulus(3'b000, 0, 0, 0, 32'h0, 0);
    checkOutput("wrap kernel pc", imemAddr, 32'h8000_0000);
    applyStimulus(3'b011, 0, 0, 0, 32'h7FFF_FFFC, 0);
    applyStimulus(3'b000, 0, 0, 0, 32'h0, 0);
    checkOutput("wrap user pc", imemAddr, 32'h0000_0000);
    checkOutput("wrap user pc4", ifIdPc4, 32'h0000_0000);
    checkOutput("pending was cleared", {31'b0, irqOut}, 32'h0);
    applyStimulus(3'b000, 0, 0, 0, 32'h0, 1);
    checkOutput("irq again", {31'b0, irqOut}, 32'h1);

    // Reset during a redirect with an interrupt pending
    reset = 1'b1;
    applyStimulus(3'b011, 0, 0, 1, 32'h0040_0300, 1);
    checkReset("mid reset");
    reset = 1'b0;
    applyStimulus(3'b000, 0, 0, 0, 32'h0, 0);
    checkOutput("after reset pc", imemAddr, 32'h8000_0004);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
